// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// slave: the unit itself; master: execute stage plus memory that surround it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_RD,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_RD,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for a word-wide memory: lane select, extension, RMW sub-word stores.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests answer at once with rsp_err.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// valid holds its payload until that edge, and ready never depends on valid.
module load_store_unit #(
  parameter int MEM_WORDS_LOG2 = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic [1:0]         dbg_state
);

  localparam int IW = MEM_WORDS_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [IW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          misalign;
  logic [1:0]    off_norm;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   lane_mask;
  logic [31:0]   merged;
  logic [31:0]   word_addr;
  logic          unused_addr_bits;

  assign accept    = (state_q == IDLE) && bus.req_valid;
  assign word_addr = {{(30-IW){1'b0}}, idx_q, 2'b00};
  assign unused_addr_bits = ^bus.req_addr[31:IW+2];

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Low address bits that the access size cannot use are dropped, not trapped.
  always_comb begin
    off_norm = 2'b00;
    case (bus.req_size)
      2'b00:   off_norm = bus.req_addr[1:0];
      2'b01:   off_norm = {bus.req_addr[1], 1'b0};
      default: off_norm = 2'b00;
    endcase
  end

  always_comb begin
    shifted   = bus.mem_RD >> {off_q, 3'b000};
    load_val  = bus.mem_RD;
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        load_val  = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << {off_q, 3'b000};
      end
      2'b01: begin
        load_val  = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << {off_q, 3'b000};
      end
      default: begin
        load_val  = bus.mem_RD;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    merged = (bus.mem_RD & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Memory strobes come only from the state register so reset kills them at once.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_A     = 32'h0;
    bus.mem_WD    = 32'h0;
    bus.mem_WE    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (misalign)          state_d = RESP;
          else if (!bus.req_we)  state_d = READ;
          else if (bus.req_size[1]) state_d = WRITE;
          else                   state_d = READ;
        end
      end
      READ: begin
        bus.mem_A = word_addr;
        state_d   = we_q ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_A  = word_addr;
        bus.mem_WD = wdata_q;
        bus.mem_WE = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      idx_q   <= bus.req_addr[IW+1:2];
      off_q   <= off_norm;
      wdata_q <= bus.req_wdata;
      rdata_q <= 32'h0;
      err_q   <= misalign;
    end else if (state_q == READ) begin
      if (we_q) wdata_q <= merged;
      else      rdata_q <= load_val;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state_q;

endmodule
